// File: rtl/counter_month_pkg.sv
// Shared constants and helpers for the BCD calendar counters (day/month/year).
package counter_month_pkg;

   localparam int unsigned BCD_W = 4;

   localparam logic [2*BCD_W-1:0] MONTH_FEB = 8'h02;
   localparam logic [2*BCD_W-1:0] MONTH_DEC = 8'h12;

   // Months with 30 days, BCD encoded
   localparam logic [2*BCD_W-1:0] MONTH_30_DAY [4] = '{8'h04, 8'h06, 8'h09, 8'h11};

   function automatic logic is_30_day(input logic [2*BCD_W-1:0] month);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (month == MONTH_30_DAY[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   // Binary month to two BCD digits {ten, unit}; anything outside 1..12 becomes 01
   function automatic logic [2*BCD_W-1:0] month_to_bcd(input int unsigned month);
      int unsigned m;
      m = (month < 1 || month > 12) ? 1 : month;
      return {BCD_W'(m / 10), BCD_W'(m % 10)};
   endfunction

endpackage

// File: rtl/counter_month_led7.sv
// BCD to 7-segment decoder (Led7thanh), active-low, seg = {g,f,e,d,c,b,a}.
// Non-BCD codes blank the digit.
module counter_month_led7 (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure lookup of the segment pattern
   always_comb begin
      unique case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/counter_month_sync_edge.sv
// Two-flop synchronizer plus gated rising-edge detect for an asynchronous pushbutton.
module counter_month_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   input  logic enable,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic adj_q;

   // Synchronize the raw button and keep the previous synchronized level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         adj_q <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         adj_q <= sync2;
      end
   end

   // Enable gates the edge directly, so dropping it mid-press leaves nothing pending
   assign rise = sync2 & ~adj_q & enable;

endmodule

// File: rtl/counter_month.sv
// BCD month counter 01..12, advanced by the day counter's end-of-month carry.
// Define COUNTER_MONTH_SET_EN to enable the manual adjust path (set_mode / adj_m);
// without it those ports are ignored and the count moves only on cm1.
module counter_month #(
   parameter int unsigned INIT_MONTH = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cm1,
   input  logic       set_mode,
   input  logic       adj_m,
   output logic [6:0] seg_m1,
   output logic [6:0] seg_m2,
   output logic       detect_2,
   output logic       detect_30_31,
   output logic       cy1
);
   import counter_month_pkg::*;

   localparam logic [2*BCD_W-1:0] INIT_BCD = month_to_bcd(INIT_MONTH);

   logic [BCD_W-1:0]   count_unit;
   logic [BCD_W-1:0]   count_ten;
   logic [BCD_W-1:0]   unit_d;
   logic [BCD_W-1:0]   ten_d;
   logic [2*BCD_W-1:0] month;
   logic               illegal;
   logic               adj_rise;

`ifdef COUNTER_MONTH_SET_EN
   counter_month_sync_edge u_adj_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (adj_m),
      .enable  (set_mode),
      .rise    (adj_rise)
   );
`else
   logic unused_adj;
   assign unused_adj = set_mode ^ adj_m;
   assign adj_rise   = 1'b0;
`endif

   assign month   = {count_ten, count_unit};
   assign illegal = (count_unit > 4'd9) || (count_ten > 4'd1) || (month == 8'h00) ||
                    ((count_ten == 4'd1) && (count_unit > 4'd2));

   // Next count: cm1 and adj_rise both request one increment, so a simultaneous
   // adjust edge is simply absorbed by the cm1 step rather than queued
   always_comb begin
      unit_d = count_unit;
      ten_d  = count_ten;
      if (cm1 || adj_rise) begin
         if (illegal || (month == MONTH_DEC)) begin
            ten_d  = 4'd0;
            unit_d = 4'd1;
         end else if (count_unit == 4'd9) begin
            ten_d  = count_ten + 4'd1;
            unit_d = 4'd0;
         end else begin
            unit_d = count_unit + 4'd1;
         end
      end
   end

   // Month count register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_ten  <= INIT_BCD[2*BCD_W-1:BCD_W];
         count_unit <= INIT_BCD[BCD_W-1:0];
      end else begin
         count_ten  <= ten_d;
         count_unit <= unit_d;
      end
   end

   // Month-length flags for the day counter and the year carry; an illegal count
   // can never equal 12, so recovery never produces cy1
   assign detect_2     = (month == MONTH_FEB);
   assign detect_30_31 = is_30_day(month);
   assign cy1          = cm1 && (month == MONTH_DEC);

   counter_month_led7 u_led_m1 (
      .bcd (count_unit),
      .seg (seg_m1)
   );

   counter_month_led7 u_led_m2 (
      .bcd (count_ten),
      .seg (seg_m2)
   );

endmodule

// File: tb/tb_counter_month.sv
// Self-checking bench for counter_month against a binary month model.
module tb_counter_month;

   logic       clk;
   logic       reset_n;
   logic       cm1;
   logic       set_mode;
   logic       adj_m;
   logic [6:0] seg_m1;
   logic [6:0] seg_m2;
   logic       detect_2;
   logic       detect_30_31;
   logic       cy1;

   int errors;
   int checks;
   int model_month;

   counter_month dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cm1          (cm1),
      .set_mode     (set_mode),
      .adj_m        (adj_m),
      .seg_m1       (seg_m1),
      .seg_m2       (seg_m2),
      .detect_2     (detect_2),
      .detect_30_31 (detect_30_31),
      .cy1          (cy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Active-low {g,f,e,d,c,b,a} glyphs for a decimal digit
   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected {seg_m2, seg_m1, detect_2, detect_30_31, cy1} for a month and cm1 level
   function automatic logic [16:0] exp_vec(input int m, input bit c);
      logic d30;
      d30 = (m == 4) || (m == 6) || (m == 9) || (m == 11);
      return {glyph(m / 10), glyph(m % 10), 1'(m == 2), d30, 1'(c && m == 12)};
   endfunction

   function automatic int next_month(input int m);
      return (m == 12) ? 1 : m + 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      cm1 = 1'b0;
      set_mode = 1'b0;
      adj_m = 1'b0;
      reset_n = 1'b0;
      #7;
      tick();
      reset_n = 1'b1;
      model_month = 1;
      tick();
   endtask

   // Advance the DUT by one cm1 pulse without checking
   task automatic step_cm1();
      cm1 = 1'b1;
      tick();
      cm1 = 1'b0;
      model_month = next_month(model_month);
   endtask

   task automatic test_reset();
      reset_dut();
      checks++;
      if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(1, 1'b0)) begin
         errors++;
         $display("FAIL reset_default got=%b want=%b",
                  {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(1, 1'b0));
      end
      // Reach 07, then assert reset away from any clock edge
      for (int i = 0; i < 6; i++) step_cm1();
      checks++;
      if ({seg_m2, seg_m1} !== {glyph(0), glyph(7)}) begin
         errors++;
         $display("FAIL reset_reach_07 got=%b want=%b", {seg_m2, seg_m1}, {glyph(0), glyph(7)});
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(1, 1'b0)) begin
         errors++;
         $display("FAIL reset_async got=%b want=%b",
                  {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(1, 1'b0));
      end
      tick();
      reset_n = 1'b1;
      model_month = 1;
      tick();
   endtask

   task automatic test_full_year();
      reset_dut();
      for (int i = 0; i < 12; i++) begin
         cm1 = 1'b1;
         #1;
         checks++;
         if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(model_month, 1'b1)) begin
            errors++;
            $display("FAIL year_cm1_cycle month=%0d got=%b want=%b", model_month,
                     {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(model_month, 1'b1));
         end
         tick();
         cm1 = 1'b0;
         model_month = next_month(model_month);
         #1;
         checks++;
         if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(model_month, 1'b0)) begin
            errors++;
            $display("FAIL year_after month=%0d got=%b want=%b", model_month,
                     {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(model_month, 1'b0));
         end
      end
   endtask

   task automatic test_tens_carry();
      reset_dut();
      for (int i = 0; i < 8; i++) step_cm1();
      checks++;
      if ({seg_m2, seg_m1, detect_30_31} !== {glyph(0), glyph(9), 1'b1}) begin
         errors++;
         $display("FAIL carry_at_09 got=%b want=%b", {seg_m2, seg_m1, detect_30_31},
                  {glyph(0), glyph(9), 1'b1});
      end
      step_cm1();
      checks++;
      if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(10, 1'b0)) begin
         errors++;
         $display("FAIL carry_to_10 got=%b want=%b",
                  {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(10, 1'b0));
      end
   endtask

   task automatic test_adjust();
      int expect_m;
      reset_dut();
      for (int i = 0; i < 11; i++) step_cm1();
      // Press at month 12 with set_mode on
      set_mode = 1'b1;
      adj_m = 1'b1;
`ifdef COUNTER_MONTH_SET_EN
      expect_m = 1;
`else
      expect_m = 12;
`endif
      for (int e = 1; e <= 5; e++) begin
         tick();
         checks++;
         if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !==
             exp_vec((e >= 3) ? expect_m : 12, 1'b0)) begin
            errors++;
            $display("FAIL adjust_edge%0d got=%b want=%b", e,
                     {seg_m2, seg_m1, detect_2, detect_30_31, cy1},
                     exp_vec((e >= 3) ? expect_m : 12, 1'b0));
         end
      end
      adj_m = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      // Same press with set_mode off: never moves
      set_mode = 1'b0;
      adj_m = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      adj_m = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(expect_m, 1'b0)) begin
         errors++;
         $display("FAIL adjust_gated got=%b want=%b",
                  {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(expect_m, 1'b0));
      end
      // set_mode dropped before the synchronized edge arrives: nothing pending
      set_mode = 1'b1;
      adj_m = 1'b1;
      tick();
      set_mode = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      adj_m = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if ({seg_m2, seg_m1} !== {glyph(expect_m / 10), glyph(expect_m % 10)}) begin
         errors++;
         $display("FAIL adjust_mode_drop got=%b want=%b", {seg_m2, seg_m1},
                  {glyph(expect_m / 10), glyph(expect_m % 10)});
      end
   endtask

   task automatic test_back_to_back();
      reset_dut();
      step_cm1();
      step_cm1();
      // Month 03: adjust edge reaches the counter in the same cycle as cm1
      set_mode = 1'b1;
      adj_m = 1'b1;
      tick();
      tick();
      cm1 = 1'b1;
      tick();
      cm1 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      adj_m = 1'b0;
      set_mode = 1'b0;
      tick();
      checks++;
      if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(4, 1'b0)) begin
         errors++;
         $display("FAIL back_to_back got=%b want=%b",
                  {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(4, 1'b0));
      end
   endtask

   task automatic test_illegal();
      reset_dut();
      @(posedge clk);
      #1;
      dut.count_ten = 4'd1;
      dut.count_unit = 4'd5;
      cm1 = 1'b1;
      #1;
      checks++;
      if ({seg_m2, seg_m1, cy1} !== {glyph(1), glyph(5), 1'b0}) begin
         errors++;
         $display("FAIL illegal_15 got=%b want=%b", {seg_m2, seg_m1, cy1},
                  {glyph(1), glyph(5), 1'b0});
      end
      tick();
      cm1 = 1'b0;
      #1;
      checks++;
      if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(1, 1'b0)) begin
         errors++;
         $display("FAIL illegal_recover got=%b want=%b",
                  {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(1, 1'b0));
      end
   endtask

   task automatic test_random();
      bit c;
      reset_dut();
      for (int i = 0; i < 300; i++) begin
         c = ($urandom_range(0, 2) == 0);
         cm1 = c;
         adj_m = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if ({seg_m2, seg_m1, detect_2, detect_30_31, cy1} !== exp_vec(model_month, c)) begin
            errors++;
            $display("FAIL random_%0d month=%0d got=%b want=%b", i, model_month,
                     {seg_m2, seg_m1, detect_2, detect_30_31, cy1}, exp_vec(model_month, c));
         end
         tick();
         cm1 = 1'b0;
         if (c) model_month = next_month(model_month);
      end
      adj_m = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      model_month = 1;
      cm1 = 1'b0;
      set_mode = 1'b0;
      adj_m = 1'b0;
      reset_n = 1'b0;
      test_reset();
      test_full_year();
      test_tens_carry();
      test_adjust();
      test_back_to_back();
      test_illegal();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
